// File: rtl/sprite_io_regs.sv
// sprite_io_regs: memory-mapped sprite attribute block on the CPU I/O bus.
// The CPU writes a shadow table. A commit request copies shadow to active at the
// next vblank_start, so the renderer never sees a half-updated frame. The block
// also keeps a sticky vblank flag and a 16-bit frame counter.
// Optional feature macro: SPRITE_IO_READBACK_EN (sprite X/Y/ATTR offsets read
// the shadow table; when undefined they read 0 and only CTRL/STAT/FRAME read back).
// DATA_W is expected to match the CPU word width (`CPU_WIDTH).
module sprite_io_regs #(
  parameter int          DATA_W      = 16,
  parameter int          NUM_SPRITES = 8,
  parameter logic [7:0]  BASE_HI     = 8'h40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] io_addr,
  input  logic              io_write,
  input  logic [DATA_W-1:0] io_wr_data,
  output logic [DATA_W-1:0] io_rd_data,
  input  logic              vblank_start,
  input  logic [4:0]        spr_index,
  output logic [9:0]        spr_x,
  output logic [9:0]        spr_y,
  output logic              spr_en,
  output logic [5:0]        spr_tile
);

  localparam int         IDX_W     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [7:0] OFF_CTRL  = 8'h80;
  localparam logic [7:0] OFF_STAT  = 8'h81;
  localparam logic [7:0] OFF_FRAME = 8'h82;

  // Shadow (CPU-facing) and active (renderer-facing) sprite tables
  logic [9:0] r_sh_x    [NUM_SPRITES];
  logic [9:0] r_sh_y    [NUM_SPRITES];
  logic       r_sh_en   [NUM_SPRITES];
  logic [5:0] r_sh_tile [NUM_SPRITES];
  logic [9:0] r_ac_x    [NUM_SPRITES];
  logic [9:0] r_ac_y    [NUM_SPRITES];
  logic       r_ac_en   [NUM_SPRITES];
  logic [5:0] r_ac_tile [NUM_SPRITES];

  logic        r_pending;
  logic        r_vbl_flag;
  logic [15:0] r_frame;

  logic             w_sel;
  logic [7:0]       w_off;
  logic [IDX_W-1:0] w_slot;
  logic             w_slot_ok;
  logic             w_wr;
  logic             w_commit;
  logic             w_ctrl_set;
  logic             w_stat_clr;
  logic             w_frame_ld;
  logic [IDX_W-1:0] w_spr_idx;
  logic             w_spr_ok;
  logic             w_unused_bits;

  assign w_sel      = (io_addr[15:8] == BASE_HI);
  assign w_off      = io_addr[7:0];
  // Sprite slots live in offsets 0x00-0x7F, four registers per sprite
  assign w_slot     = w_off[2 +: IDX_W];
  assign w_slot_ok  = !w_off[7] && (int'(w_off[6:2]) < NUM_SPRITES);
  assign w_wr       = io_write && w_sel;
  assign w_commit   = vblank_start && r_pending;
  assign w_ctrl_set = w_wr && (w_off == OFF_CTRL) && io_wr_data[0];
  assign w_stat_clr = w_wr && (w_off == OFF_STAT) && io_wr_data[0];
  assign w_frame_ld = w_wr && (w_off == OFF_FRAME);
  assign w_spr_idx  = spr_index[IDX_W-1:0];
  assign w_spr_ok   = (int'(spr_index) < NUM_SPRITES);
  // ATTR bits between enable and tile carry no state
  assign w_unused_bits = ^io_wr_data[14:10];

  // CPU writes into the shadow table; unused upper bits are dropped here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_sh_x[i]    <= '0;
        r_sh_y[i]    <= '0;
        r_sh_en[i]   <= 1'b0;
        r_sh_tile[i] <= '0;
      end
    end else if (w_wr && w_slot_ok) begin
      case (w_off[1:0])
        2'd0: r_sh_x[w_slot] <= io_wr_data[9:0];
        2'd1: r_sh_y[w_slot] <= io_wr_data[9:0];
        2'd2: begin
          r_sh_en[w_slot]   <= io_wr_data[15];
          r_sh_tile[w_slot] <= io_wr_data[5:0];
        end
        default: ;
      endcase
    end
  end

  // Whole-table copy on commit; a same-edge shadow write lands after this copy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_ac_x[i]    <= '0;
        r_ac_y[i]    <= '0;
        r_ac_en[i]   <= 1'b0;
        r_ac_tile[i] <= '0;
      end
    end else if (w_commit) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_ac_x[i]    <= r_sh_x[i];
        r_ac_y[i]    <= r_sh_y[i];
        r_ac_en[i]   <= r_sh_en[i];
        r_ac_tile[i] <= r_sh_tile[i];
      end
    end
  end

  // Control state: CTRL set beats commit clear, vblank set beats W1C, FRAME load beats increment
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_vbl_flag <= 1'b0;
      r_frame    <= '0;
    end else begin
      if (w_ctrl_set)
        r_pending <= 1'b1;
      else if (w_commit)
        r_pending <= 1'b0;

      if (vblank_start)
        r_vbl_flag <= 1'b1;
      else if (w_stat_clr)
        r_vbl_flag <= 1'b0;

      if (w_frame_ld)
        r_frame <= io_wr_data[15:0];
      else if (vblank_start)
        r_frame <= r_frame + 16'd1;
    end
  end

  // Zero-latency read mux: the CPU captures io_rd_data on the same edge
  always_comb begin
    io_rd_data = '0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:  io_rd_data = DATA_W'(r_pending);
        OFF_STAT:  io_rd_data = DATA_W'(r_vbl_flag);
        OFF_FRAME: io_rd_data = DATA_W'(r_frame);
        default: begin
`ifdef SPRITE_IO_READBACK_EN
          if (w_slot_ok) begin
            case (w_off[1:0])
              2'd0:    io_rd_data = DATA_W'(r_sh_x[w_slot]);
              2'd1:    io_rd_data = DATA_W'(r_sh_y[w_slot]);
              2'd2:    io_rd_data = DATA_W'({r_sh_en[w_slot], 9'b0, r_sh_tile[w_slot]});
              default: io_rd_data = '0;
            endcase
          end
`endif
        end
      endcase
    end
  end

  // Renderer lookup into the active table; out-of-range index reads as an empty sprite
  always_comb begin
    spr_x    = '0;
    spr_y    = '0;
    spr_en   = 1'b0;
    spr_tile = '0;
    if (w_spr_ok) begin
      spr_x    = r_ac_x[w_spr_idx];
      spr_y    = r_ac_y[w_spr_idx];
      spr_en   = r_ac_en[w_spr_idx];
      spr_tile = r_ac_tile[w_spr_idx];
    end
  end

endmodule

// File: tb/tb_sprite_io_regs.sv
// Self-checking bench for sprite_io_regs: expected read values are queued when
// the stimulus is driven and popped when the DUT output is sampled.
module tb_sprite_io_regs;

  logic        clock;
  logic        reset;
  logic [15:0] io_addr;
  logic        io_write;
  logic [15:0] io_wr_data;
  logic [15:0] io_rd_data;
  logic        vblank_start;
  logic [4:0]  spr_index;
  logic [9:0]  spr_x;
  logic [9:0]  spr_y;
  logic        spr_en;
  logic [5:0]  spr_tile;

  int checks = 0;
  int errors = 0;

  logic [15:0] rd_q  [$];
  logic [26:0] spr_q [$];

`ifdef SPRITE_IO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  sprite_io_regs #(.DATA_W(16), .NUM_SPRITES(8), .BASE_HI(8'h40)) dut (
    .clock(clock), .reset(reset), .io_addr(io_addr), .io_write(io_write),
    .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .vblank_start(vblank_start),
    .spr_index(spr_index), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
    .spr_tile(spr_tile)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // One bus cycle: optional write and optional vblank pulse on the same edge
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w, input logic vb);
    @(negedge clock);
    io_addr = a; io_wr_data = d; io_write = w; vblank_start = vb;
    @(posedge clock); #1;
    io_write = 1'b0; vblank_start = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(a, d, 1'b1, 1'b0);
  endtask

  task automatic vbl();
    cyc(16'h0000, 16'h0000, 1'b0, 1'b1);
  endtask

  function automatic logic [26:0] spr_pack(input logic [9:0] x, input logic [9:0] y,
                                           input logic en, input logic [5:0] t);
    return {x, y, en, t};
  endfunction

  task automatic test_reset();
    logic [15:0] addrs [3];
    logic [15:0] got, exp;
    logic [26:0] sgot, sexp;
    addrs = '{16'h4080, 16'h4081, 16'h4082};
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    foreach (addrs[i]) rd_q.push_back(16'h0000);
    for (int i = 0; i < 8; i++) spr_q.push_back(27'd0);
    foreach (addrs[i]) begin
      @(negedge clock); io_addr = addrs[i]; #1;
      got = io_rd_data; exp = rd_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_rd addr=%h got=%h want=%h", addrs[i], got, exp); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock); spr_index = 5'(i); #1;
      sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = spr_q.pop_front(); checks++;
      if (sgot !== sexp) begin errors++; $display("FAIL reset_spr idx=%0d got=%h want=%h", i, sgot, sexp); end
    end
  endtask

  task automatic test_shadow_isolation();
    logic [15:0] addrs [3];
    logic [15:0] got, exp;
    logic [26:0] sgot, sexp;
    addrs = '{16'h4082, 16'h4081, 16'h4080};
    wr(16'h4000, 16'd123);
    wr(16'h4002, 16'h8005);
    vbl();
    spr_q.push_back(27'd0);
    rd_q.push_back(16'd1); rd_q.push_back(16'd1); rd_q.push_back(16'd0);
    @(negedge clock); spr_index = 5'd0; #1;
    sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = spr_q.pop_front(); checks++;
    if (sgot !== sexp) begin errors++; $display("FAIL iso_spr0 got=%h want=%h", sgot, sexp); end
    foreach (addrs[i]) begin
      @(negedge clock); io_addr = addrs[i]; #1;
      got = io_rd_data; exp = rd_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL iso_rd addr=%h got=%h want=%h", addrs[i], got, exp); end
    end
  endtask

  task automatic test_commit();
    logic [15:0] addrs [5];
    logic [15:0] got, exp;
    logic [26:0] sgot, sexp;
    wr(16'h4080, 16'h0001);
    wr(16'h4080, 16'h0002);
    wr(16'h4001, 16'hFFFF);
    rd_q.push_back(16'h0001);
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL commit_pending got=%h want=%h", got, exp); end
    vbl();
    spr_q.push_back(spr_pack(10'd123, 10'h3FF, 1'b1, 6'd5));
    addrs = '{16'h4080, 16'h4082, 16'h4000, 16'h4001, 16'h4002};
    rd_q.push_back(16'h0000); rd_q.push_back(16'd2);
    rd_q.push_back(RB ? 16'd123 : 16'd0);
    rd_q.push_back(RB ? 16'h03FF : 16'd0);
    rd_q.push_back(RB ? 16'h8005 : 16'd0);
    @(negedge clock); spr_index = 5'd0; #1;
    sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = spr_q.pop_front(); checks++;
    if (sgot !== sexp) begin errors++; $display("FAIL commit_spr0 got=%h want=%h", sgot, sexp); end
    foreach (addrs[i]) begin
      @(negedge clock); io_addr = addrs[i]; #1;
      got = io_rd_data; exp = rd_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL commit_rd addr=%h got=%h want=%h", addrs[i], got, exp); end
    end
  endtask

  task automatic test_flag();
    logic [15:0] got, exp;
    // flag is 1 from the previous vblank; writing 0 must not clear it
    wr(16'h4081, 16'h0000); rd_q.push_back(16'd1);
    @(negedge clock); io_addr = 16'h4081; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flag_w0 got=%h want=%h", got, exp); end
    wr(16'h4081, 16'h0001); rd_q.push_back(16'd0);
    @(negedge clock); io_addr = 16'h4081; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flag_w1c got=%h want=%h", got, exp); end
    vbl(); rd_q.push_back(16'd1);
    @(negedge clock); io_addr = 16'h4081; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flag_set got=%h want=%h", got, exp); end
    wr(16'h4081, 16'h0001);
    cyc(16'h4081, 16'h0001, 1'b1, 1'b1); rd_q.push_back(16'd1);
    @(negedge clock); io_addr = 16'h4081; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flag_collide got=%h want=%h", got, exp); end
    rd_q.push_back(16'd4);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flag_frame got=%h want=%h", got, exp); end
  endtask

  task automatic test_frame();
    logic [15:0] got, exp;
    wr(16'h4082, 16'hFFFF); rd_q.push_back(16'hFFFF);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL frame_load got=%h want=%h", got, exp); end
    vbl(); rd_q.push_back(16'h0000);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL frame_wrap got=%h want=%h", got, exp); end
    cyc(16'h4082, 16'd7, 1'b1, 1'b1); rd_q.push_back(16'd7);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL frame_collide got=%h want=%h", got, exp); end
    vbl(); rd_q.push_back(16'd8);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL frame_inc got=%h want=%h", got, exp); end
  endtask

  task automatic test_collision();
    logic [15:0] got, exp;
    logic [9:0]  xg, xe;
    wr(16'h4000, 16'd200);
    wr(16'h4080, 16'h0001);
    // shadow write on the commit edge: active takes 200, shadow keeps 9
    cyc(16'h4000, 16'd9, 1'b1, 1'b1);
    spr_q.push_back(spr_pack(10'd200, 10'h3FF, 1'b1, 6'd5));
    rd_q.push_back(RB ? 16'd9 : 16'd0);
    rd_q.push_back(16'd0);
    @(negedge clock); spr_index = 5'd0; #1;
    begin
      logic [26:0] sg, se;
      sg = {spr_x, spr_y, spr_en, spr_tile}; se = spr_q.pop_front(); checks++;
      if (sg !== se) begin errors++; $display("FAIL coll_wr_spr got=%h want=%h", sg, se); end
    end
    @(negedge clock); io_addr = 16'h4000; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_wr_shadow got=%h want=%h", got, exp); end
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_wr_ctrl got=%h want=%h", got, exp); end
    // CTRL set with vblank while idle: no commit, pending afterwards
    cyc(16'h4080, 16'h0001, 1'b1, 1'b1);
    spr_q.push_back({10'd200, 17'd0}); rd_q.push_back(16'd1);
    @(negedge clock); spr_index = 5'd0; #1;
    xg = spr_x; xe = spr_q.pop_front()[26:17]; checks++;
    if (xg !== xe) begin errors++; $display("FAIL coll_set_idle_x got=%h want=%h", xg, xe); end
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_set_idle_ctrl got=%h want=%h", got, exp); end
    // CTRL set with vblank while pending: commit and stay pending
    wr(16'h4000, 16'd77);
    cyc(16'h4080, 16'h0001, 1'b1, 1'b1);
    spr_q.push_back({10'd77, 17'd0}); rd_q.push_back(16'd1);
    @(negedge clock); spr_index = 5'd0; #1;
    xg = spr_x; xe = spr_q.pop_front()[26:17]; checks++;
    if (xg !== xe) begin errors++; $display("FAIL coll_set_pend_x got=%h want=%h", xg, xe); end
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_set_pend_ctrl got=%h want=%h", got, exp); end
    vbl(); rd_q.push_back(16'd0);
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL coll_drain_ctrl got=%h want=%h", got, exp); end
  endtask

  task automatic test_decode();
    logic [15:0] addrs [6];
    logic [15:0] got, exp;
    logic [26:0] sgot, sexp;
    wr(16'h4100, 16'd55);
    wr(16'h4020, 16'd55);
    wr(16'h4003, 16'hFFFF);
    wr(16'h4083, 16'h1234);
    wr(16'h3F80, 16'h0001);
    addrs = '{16'h4100, 16'h4020, 16'h4003, 16'h4083, 16'h3F80, 16'h4080};
    foreach (addrs[i]) rd_q.push_back(16'h0000);
    foreach (addrs[i]) begin
      @(negedge clock); io_addr = addrs[i]; #1;
      got = io_rd_data; exp = rd_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL decode_rd addr=%h got=%h want=%h", addrs[i], got, exp); end
    end
    // sprite 7 fields, then commit to confirm stray writes never reached sprite 0
    wr(16'h401C, 16'd511);
    wr(16'h401E, 16'h803F);
    wr(16'h4080, 16'h0001);
    vbl();
    spr_q.push_back(spr_pack(10'd77, 10'h3FF, 1'b1, 6'd5));
    spr_q.push_back(spr_pack(10'd511, 10'd0, 1'b1, 6'h3F));
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); spr_index = (i == 0) ? 5'd0 : 5'd7; #1;
      sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = spr_q.pop_front(); checks++;
      if (sgot !== sexp) begin errors++; $display("FAIL decode_spr idx=%0d got=%h want=%h", spr_index, sgot, sexp); end
    end
    rd_q.push_back(16'd13);
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL decode_frame got=%h want=%h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got, exp;
    logic [26:0] sgot, sexp;
    wr(16'h4004, 16'd300);
    wr(16'h4080, 16'h0001);
    @(negedge clock); spr_index = 5'd7; #2;
    reset = 1'b1; #1;
    sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = 27'd0; checks++;
    if (sgot !== sexp) begin errors++; $display("FAIL rstmid_async got=%h want=%h", sgot, sexp); end
    rd_q.push_back(16'd0); rd_q.push_back(16'd0);
    @(negedge clock); io_addr = 16'h4080; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstmid_ctrl got=%h want=%h", got, exp); end
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstmid_frame got=%h want=%h", got, exp); end
    @(negedge clock); reset = 1'b0;
    vbl();
    spr_q.push_back(27'd0); rd_q.push_back(16'd1);
    @(negedge clock); spr_index = 5'd1; #1;
    sgot = {spr_x, spr_y, spr_en, spr_tile}; sexp = spr_q.pop_front(); checks++;
    if (sgot !== sexp) begin errors++; $display("FAIL rstmid_nocommit got=%h want=%h", sgot, sexp); end
    @(negedge clock); io_addr = 16'h4082; #1;
    got = io_rd_data; exp = rd_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rstmid_frame_after got=%h want=%h", got, exp); end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; io_addr = '0; io_write = 1'b0;
    io_wr_data = '0; vblank_start = 1'b0; spr_index = '0;
    test_reset();
    test_shadow_isolation();
    test_commit();
    test_flag();
    test_frame();
    test_collision();
    test_decode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
